// File: rtl/mult4_seq.sv
// Sequential 4x4 unsigned shift-and-add multiplier built around one time-shared
// full_adder4; start/busy/done handshake, one multiplication in flight at a time.

module full_adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out
);

  logic [4:0] carry;

  // Ripple-carry chain
  always_comb begin
    sum      = '0;
    carry    = '0;
    carry[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      sum[i]     = a[i] ^ b[i] ^ carry[i];
      carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign c_out = carry[4];

endmodule

module mult4_seq #(
  parameter int unsigned N_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_BITS-1:0]     a,
  input  logic [N_BITS-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*N_BITS-1:0]   product
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned LAST_I = N_BITS - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [N_BITS-1:0]   mcand;
  logic [N_BITS-1:0]   hi;
  logic [N_BITS-1:0]   lo;
  logic [CNT_W-1:0]    cnt;
  logic [N_BITS-1:0]   addend;
  logic [N_BITS-1:0]   s;
  logic                co;

  // Add the multiplicand into the accumulator only when the current multiplier bit is set
  assign addend = lo[0] ? mcand : '0;

  full_adder4 u_adder (
    .a     (hi),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (s),
    .c_out (co)
  );

  // State register; busy/done are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_CALC);
      done  <= (state_next == ST_DONE);
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_CALC;
      ST_CALC: if (cnt == CNT_W'(LAST_I)) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture in IDLE, one shift-add iteration per CALC cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
          end
        end
        ST_CALC: begin
          hi  <= {co, s[N_BITS-1:1]};
          lo  <= {s[0], lo[N_BITS-1:1]};
          cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign product = {hi, lo};

endmodule

// File: tb/tb_mult4_seq.sv
// Self-checking bench for mult4_seq: vector table plus handshake corner cases,
// with a scoreboard queue of expected products popped on each done pulse.

module tb_mult4_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t vecs[8];

  mult4_seq #(.N_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (busy) chk("busy_and_done", 1, 0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        chk("sb_product", int'(product), int'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    for (int i = 0; i < budget; i++) begin
      tick();
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  task automatic run_op(input logic [3:0] va, input logic [3:0] vb, input logic [7:0] exp);
    int busy_cyc;
    int lat;
    bit ok;
    a     = va;
    b     = vb;
    start = 1'b1;
    sb.push_back(exp);
    tick();
    start    = 1'b0;
    a        = ~va;
    b        = ~vb;
    busy_cyc = busy ? 1 : 0;
    lat      = 0;
    ok       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cyc++;
    end
    if (!ok) chk("done_timeout", 0, 1);
    chk("latency", lat, 4);
    chk("busy_cycles", busy_cyc, 4);
    chk("product_at_done", int'(product), int'(exp));
    tick();
    chk("done_one_cycle", int'(done), 0);
    chk("product_held", int'(product), int'(exp));
    tick();
  endtask

  initial begin
    int lat;
    int t1;
    int t2;
    int dc;
    bit ok;

    vecs[0] = '{4'd13, 4'd11, 8'd143};
    vecs[1] = '{4'd15, 4'd15, 8'hE1};
    vecs[2] = '{4'd0,  4'd9,  8'd0};
    vecs[3] = '{4'd7,  4'd1,  8'd7};
    vecs[4] = '{4'd1,  4'd15, 8'd15};
    vecs[5] = '{4'd8,  4'd8,  8'd64};
    vecs[6] = '{4'd6,  4'd10, 8'd60};
    vecs[7] = '{4'd15, 4'd0,  8'd0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) tick();
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_product", int'(product), 0);
    end

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].p);

    // Start pulsed while busy must be ignored
    dc    = done_cnt;
    a     = 4'd3;
    b     = 4'd5;
    start = 1'b1;
    sb.push_back(8'd15);
    tick();
    start = 1'b0;
    tick();
    a     = 4'd15;
    b     = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(8, lat, ok);
    chk("busy_start_product", int'(product), 15);
    repeat (10) tick();
    chk("busy_start_done_count", done_cnt - dc, 1);

    // Reset mid-operation discards the result
    dc    = done_cnt;
    a     = 4'd9;
    b     = 4'd9;
    start = 1'b1;
    sb.push_back(8'd81);
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_product", int'(product), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("midrst_no_done", done_cnt - dc, 0);
    run_op(4'd2, 4'd6, 8'd12);

    // Back-to-back with start held; operands changed before re-acceptance
    a     = 4'd4;
    b     = 4'd4;
    start = 1'b1;
    sb.push_back(8'd16);
    sb.push_back(8'd15);
    tick();
    a = 4'd5;
    b = 4'd3;
    wait_done(8, lat, ok);
    t1 = cyc;
    chk("b2b_first", int'(product), 16);
    tick();
    tick();
    start = 1'b0;
    chk("b2b_reaccept_busy", int'(busy), 1);
    wait_done(10, lat, ok);
    t2 = cyc;
    chk("b2b_second", int'(product), 15);
    chk("b2b_spacing", t2 - t1, 6);
    repeat (3) tick();

    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult4_seq.md
# mult4_seq

Sequential 4x4 unsigned shift-and-add multiplier that sits directly downstream of the team's `full_adder4` and consumes its `sum`/`c_out` every cycle. One `full_adder4` instance is time-shared over four iterations to produce an 8-bit product. A start/busy/done handshake lets a controller launch one multiplication at a time.

## Interface
- `N_BITS`, default 4, operand width. Only 4 is supported because the block instantiates `full_adder4`. The product is 2*N_BITS wide.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low. Ports `clk` and `rst_n`.
- `clk`, input, 1, rising-edge clock.
- `rst_n`, input, 1, asynchronous active-low reset.
- `start`, input, 1, launch request. Sampled only in IDLE.
- `a`, input, 4, multiplicand. Captured when `start` is accepted.
- `b`, input, 4, multiplier. Captured when `start` is accepted.
- `busy`, output, 1, high while in CALC.
- `done`, output, 1, single-cycle pulse when `product` becomes valid.
- `product`, output, 8, `a*b` result. Held until the next accepted start.

## Operation
- Internal registers:
  - `mcand[3:0]`, the multiplicand.
  - `hi[3:0]`, the accumulator.
  - `lo[3:0]`, the multiplier, which shifts into the product's low half.
  - `cnt[2:0]`, the iteration counter.
  - `state`, one of IDLE, CALC, DONE.
- Adder hookup (combinational):
  - `full_adder4.a` = `hi`.
  - `full_adder4.b` = `lo[0]` ? `mcand` : 4'b0000.
  - `c_in` = 0.
  - Outputs are `s[3:0]` and `co`.
- IDLE:
  - If `start`=1: `mcand`<=`a`, `lo`<=`b`, `hi`<=0, `cnt`<=0, go to CALC.
  - Otherwise stay in IDLE.
- CALC, each cycle (one iteration):
  - `hi`<={`co`, `s[3:1]`}.
  - `lo`<={`s[0]`, `lo[3:1]`}.
  - `cnt`<=`cnt`+1.
  - When `cnt`==3 in this cycle, go to DONE after the update. Exactly 4 iterations are performed.
- DONE:
  - `product` is driven from the {`hi`,`lo`} registers.
  - `done`=1 for exactly this one cycle.
  - Unconditionally go to IDLE.
- `product` = {`hi`,`lo`} at all times. It is only meaningful after `done`. The bench checks it at `done` and in the following IDLE cycles.
- Width rules:
  - The accumulator never overflows: max 15*15 = 225 fits in 8 bits.
  - `co` is always captured into `hi[3]`.
- Start rules:
  - `start` in CALC or DONE is ignored. It is not queued, and a held `start` is re-sampled only once IDLE is reached.
  - Operand changes on `a`/`b` after acceptance have no effect.
- Reset:
  - Asserting `rst_n`=0 at any time, including mid-CALC, forces: state IDLE; `mcand`, `hi`, `lo`, `cnt` = 0; `busy`=0; `done`=0; `product`=8'h00.
  - The in-flight operation is discarded and no `done` pulse is produced.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=8'h00, state IDLE.
- Edge numbering: E0 is the rising edge where `start`=1 is sampled in IDLE.
- E0: operands captured; `busy` rises after E0.
- E1 to E4: four iterations. `busy`=1 in the cycles E0 to E1, E1 to E2, E2 to E3 and E3 to E4 (4 cycles).
- After E4: state DONE, `busy`=0, `done`=1, `product` valid.
- After E5: IDLE, `done`=0, `product` held.
- Start-to-done latency is 4 cycles, measured from the accepting edge to the edge that raises `done`.
- Back-to-back throughput is one result per 6 cycles: `start` held high is re-accepted at E6.
- `busy` and `done` are never high simultaneously.
- `done` is registered; no output depends combinationally on `start`.

## Test plan
- **Reset:** drive `rst_n`=0 then release with `start`=0. Require `busy`=0, `done`=0 and `product`=8'h00 for 10 cycles.
- **Operand sweep:** a=13, b=11, start for 1 cycle. Require `busy`=1 for exactly 4 cycles, `done` pulsed 1 cycle, `product`=8'd143, held afterwards. Repeat with a=15, b=15, requiring `product`=8'hE1.
- **Zero and identity:** a=0, b=9 gives `product`=0. a=7, b=1 gives 7. a=1, b=15 gives 15. Each result appears with 4-cycle latency.
- **Start while busy:** a=3, b=5 accepted. One cycle later pulse `start` with a=15, b=15. Require `product`=8'd15 and exactly one `done` pulse.
- **Reset mid-operation:** a=9, b=9 accepted, then `rst_n`=0 after 2 cycles. Require immediate `busy`=0, `product`=0, and no `done`. Then run a=2, b=6, requiring `product`=12.
- **Back-to-back:** hold `start`=1 with a=4, b=4, then switch to a=5, b=3 after the first acceptance. Require `done` pulses 6 cycles apart. Require `product`=16 then 15 if the operands are changed before E6, or 16 twice if they are not.
